// File: rtl/pll_reset_seq.sv
// PLL lock sequencer: synchronizes pll_lock, waits for a stable settle period, then releases
// sys_rst and runs a ce divider. Optional PLL_RELOCK_EN adds a lock-loss timeout that pulses pll_reset.
module pll_reset_seq #(
    parameter int SETTLE_CYCLES  = 1024,
    parameter int CE_DIV         = 2,
    parameter int RELOCK_TIMEOUT = 65536,
    parameter int PLL_RST_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock,
    input  logic hold_req,
    output logic sys_rst,
    output logic ce,
    output logic ready,
    output logic pll_reset
);
    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int DIV_W = $clog2(CE_DIV) + 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

    generate
        if (SETTLE_CYCLES < 1 || CE_DIV < 1 || RELOCK_TIMEOUT < 1 || PLL_RST_CYCLES < 1) begin : g_bad_params
            $error("pll_reset_seq: all cycle-count parameters must be >= 1");
        end
    endgenerate

`ifdef PLL_RELOCK_EN
    typedef enum logic [1:0] {ST_WAIT_LOCK, ST_SETTLE, ST_RUN, ST_PLL_RST} state_t;

    localparam int TO_W = $clog2(RELOCK_TIMEOUT) + 1;
    localparam int PR_W = $clog2(PLL_RST_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RELOCK_TIMEOUT - 1);
    localparam logic [PR_W-1:0] PR_LAST = PR_W'(PLL_RST_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [PR_W-1:0] prst_cnt_q, prst_cnt_d;
    logic            pll_reset_q, pll_reset_d;
`else
    typedef enum logic [1:0] {ST_WAIT_LOCK, ST_SETTLE, ST_RUN} state_t;
`endif

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic            sys_rst_q, sys_rst_d;
    logic            ce_q, ce_d;
    logic            ready_q, ready_d;
    logic            lock_s;

    assign lock_s = sync_q[1];

    always_comb begin
        sync_d       = {sync_q[0], pll_lock};
        state_d      = state_q;
        settle_cnt_d = '0;
        div_d        = '0;
`ifdef PLL_RELOCK_EN
        to_cnt_d     = '0;
        prst_cnt_d   = '0;
`endif
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s && !hold_req) begin
                    state_d = ST_SETTLE;
                end
`ifdef PLL_RELOCK_EN
                if (!lock_s) begin
                    if (to_cnt_q == TO_LAST) begin
                        state_d = ST_PLL_RST;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
`endif
            end
            ST_SETTLE: begin
                // hold_req leaves the counter at its cleared default and stays here
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (!hold_req) begin
                    if (settle_cnt_q == SET_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (hold_req) begin
                    state_d = ST_SETTLE;
                end else if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end
            end
`ifdef PLL_RELOCK_EN
            ST_PLL_RST: begin
                if (prst_cnt_q == PR_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    prst_cnt_d = prst_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_WAIT_LOCK;
        endcase

        // Outputs are registered from the next state so they change together with it
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        ce_d      = ready_d && (div_d == DIV_LAST);
`ifdef PLL_RELOCK_EN
        pll_reset_d = (state_d == ST_PLL_RST);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_WAIT_LOCK;
            sync_q       <= '0;
            settle_cnt_q <= '0;
            div_q        <= '0;
            sys_rst_q    <= 1'b1;
            ce_q         <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            settle_cnt_q <= settle_cnt_d;
            div_q        <= div_d;
            sys_rst_q    <= sys_rst_d;
            ce_q         <= ce_d;
            ready_q      <= ready_d;
        end
    end

`ifdef PLL_RELOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q    <= '0;
            prst_cnt_q  <= '0;
            pll_reset_q <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            prst_cnt_q  <= prst_cnt_d;
            pll_reset_q <= pll_reset_d;
        end
    end

    assign pll_reset = pll_reset_q;
`else
    assign pll_reset = 1'b0;
`endif

    assign sys_rst = sys_rst_q;
    assign ce      = ce_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Randomized scoreboard bench for pll_reset_seq: three instances (CE_DIV 1/2/3) share stimulus,
// expectations come from a timestamp-based model of the release rules.
module tb_pll_reset_seq;
    localparam int S  = 8;
    localparam int RT = 32;
    localparam int PR = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pll_lock = 1'b0;
    logic hold_req = 1'b0;

    logic sys_rst2, ce2, ready2, pll_reset2;
    logic sys_rst1, ce1, ready1, pll_reset1;
    logic sys_rst3, ce3, ready3, pll_reset3;

    always #5 clk = ~clk;

    pll_reset_seq #(.SETTLE_CYCLES(S), .CE_DIV(2), .RELOCK_TIMEOUT(RT), .PLL_RST_CYCLES(PR)) u_dut2 (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .hold_req(hold_req),
        .sys_rst(sys_rst2), .ce(ce2), .ready(ready2), .pll_reset(pll_reset2));
    pll_reset_seq #(.SETTLE_CYCLES(S), .CE_DIV(1), .RELOCK_TIMEOUT(RT), .PLL_RST_CYCLES(PR)) u_dut1 (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .hold_req(hold_req),
        .sys_rst(sys_rst1), .ce(ce1), .ready(ready1), .pll_reset(pll_reset1));
    pll_reset_seq #(.SETTLE_CYCLES(S), .CE_DIV(3), .RELOCK_TIMEOUT(RT), .PLL_RST_CYCLES(PR)) u_dut3 (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .hold_req(hold_req),
        .sys_rst(sys_rst3), .ce(ce3), .ready(ready3), .pll_reset(pll_reset3));

    typedef struct {
        bit sys_rst;
        bit ready;
        bit ce1;
        bit ce2;
        bit ce3;
        bit pllr;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Model: edge index t, settle start edge, lock samples seen 1 and 2 edges ago
    int t;
    int start;
    bit waiting;
    bit lk1, lk2;
    int to_cnt;
    int pr_left;

    function automatic void model_reset();
        t = 0; start = 0; waiting = 1'b1; lk1 = 1'b0; lk2 = 1'b0; to_cnt = 0; pr_left = 0;
    endfunction

    function automatic void model_step();
        bit ls;
        t++;
        ls = lk2;
        lk2 = lk1;
        lk1 = pll_lock;
        if (pr_left > 0) begin
            pr_left--;
        end else if (!ls) begin
`ifdef PLL_RELOCK_EN
            if (waiting) begin
                if (to_cnt == RT - 1) begin
                    pr_left = PR;
                    to_cnt = 0;
                end else begin
                    to_cnt++;
                end
            end else begin
                to_cnt = 0;
            end
`endif
            waiting = 1'b1;
        end else begin
            to_cnt = 0;
            if (hold_req) begin
                if (!waiting) start = t;
            end else if (waiting) begin
                waiting = 1'b0;
                start = t;
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        bit run;
        int k;
        run = !waiting && (pr_left == 0) && (t - start >= S);
        k = t - start - S + 1;
        e.sys_rst = !run;
        e.ready = run;
        e.ce1 = run;
        e.ce2 = run && (k % 2 == 0);
        e.ce3 = run && (k % 3 == 0);
        e.pllr = (pr_left > 0);
        e.cyc = t;
        sb_q.push_back(e);
    endfunction

    task automatic tick(input bit lk, input bit hd);
        @(posedge clk);
        model_step();
        push_exp();
        #1;
        pll_lock = lk;
        hold_req = hd;
    endtask

    task automatic run_n(input int n, input bit lk, input bit hd);
        for (int i = 0; i < n; i++) tick(lk, hd);
    endtask

    // Reset lands 2 time units after an edge, so outputs must change before the next edge
    task automatic apply_reset(input int n);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        push_exp();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            push_exp();
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req, input int cyc);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d {sys_rst,ready,ce,pll_reset} got %b expected %b", name, cyc, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("div2", {sys_rst2, ready2, ce2, pll_reset2}, {e.sys_rst, e.ready, e.ce2, e.pllr}, e.cyc);
                chk("div1", {sys_rst1, ready1, ce1, pll_reset1}, {e.sys_rst, e.ready, e.ce1, e.pllr}, e.cyc);
                chk("div3", {sys_rst3, ready3, ce3, pll_reset3}, {e.sys_rst, e.ready, e.ce3, e.pllr}, e.cyc);
            end
        end
    end

    initial begin
        model_reset();
        pll_lock = 1'b1;
        repeat (3) begin
            @(posedge clk);
            push_exp();
        end
        #1;
        reset = 1'b0;

        run_n(20, 1'b1, 1'b0);          // clean release
        run_n(4, 1'b0, 1'b0);
        run_n(8, 1'b1, 1'b0);           // lock glitch mid-settle
        run_n(1, 1'b0, 1'b0);
        run_n(20, 1'b1, 1'b0);
        run_n(5, 1'b0, 1'b0);           // lock loss in RUN, then relock
        run_n(20, 1'b1, 1'b0);
        run_n(4, 1'b1, 1'b1);           // hold request in RUN
        run_n(15, 1'b1, 1'b0);
        run_n(8, 1'b1, 1'b0);           // lock loss on the terminal settle edge
        run_n(3, 1'b1, 1'b1);
        run_n(7, 1'b1, 1'b0);
        run_n(3, 1'b0, 1'b0);
        run_n(15, 1'b1, 1'b0);
        apply_reset(2);
        run_n(14, 1'b1, 1'b0);
`ifdef PLL_RELOCK_EN
        run_n(80, 1'b0, 1'b0);
        for (int i = 0; i < 200 && pr_left != 2; i++) tick(1'b0, 1'b0);
        apply_reset(0);
        run_n(20, 1'b0, 1'b0);
`endif
        for (int seg = 0; seg < 160; seg++) begin
            bit lk;
            int len;
            if ($urandom_range(0, 14) == 0) apply_reset(int'($urandom_range(0, 3)));
            lk = ($urandom_range(0, 3) != 0);
            len = lk ? int'($urandom_range(4, 40)) : int'($urandom_range(1, 10));
            for (int i = 0; i < len; i++) tick(lk, $urandom_range(0, 24) == 0);
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain queue_left=%0d expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
